// File: rtl/blob_bbox_scanner_if.sv
// Shared-bus connection between the blob scanner (bus master) and the bus/memory side.
interface blob_bbox_scanner_if;
   logic        requestBus;
   logic        busGrant;
   logic        beginTransactionOut;
   logic [31:0] addressDataOut;
   logic        readNotWriteOut;
   logic [3:0]  byteEnablesOut;
   logic [7:0]  burstSizeOut;
   logic        endTransactionOut;
   logic [31:0] addressDataIn;
   logic        dataValidIn;
   logic        endTransactionIn;
   logic        busErrorIn;

   modport master (
      output requestBus, beginTransactionOut, addressDataOut, readNotWriteOut,
             byteEnablesOut, burstSizeOut, endTransactionOut,
      input  busGrant, addressDataIn, dataValidIn, endTransactionIn, busErrorIn
   );

   modport slave (
      input  requestBus, beginTransactionOut, addressDataOut, readNotWriteOut,
             byteEnablesOut, burstSizeOut, endTransactionOut,
      output busGrant, addressDataIn, dataValidIn, endTransactionIn, busErrorIn
   );
endinterface

// File: rtl/blob_bbox_scanner.sv
// Single-pass scan of a thresholded frame in memory: foreground count, bounding box
// and X/Y coordinate sums, fetched as bursts of up to 16 words over the shared bus.
module blob_bbox_scanner #(
   parameter logic [7:0] customInstructionId = 8'd0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       ciStart,
   input  logic                       ciCke,
   input  logic [7:0]                 ciN,
   input  logic [31:0]                ciValueA,
   input  logic [31:0]                ciValueB,
   output logic [31:0]                ciResult,
   output logic                       ciDone,
   blob_bbox_scanner_if.master        bus
);
   typedef enum logic [2:0] {IDLE, REQUEST, INIT, READ, ABORT} stateType;

   stateType    state, nextState;
   logic [31:0] base, address;
   logic [9:0]  width, height, x, y;
   logic [17:0] wordsLeft;
   logic        done, error, drainDone;
   logic [9:0]  minX, minY, maxX, maxY;
   logic [19:0] count;
   logic [31:0] sumX, sumY;
   logic        pipeValid;
   logic [31:0] pipeWord;
   logic [9:0]  pipeX, pipeY;
   logic        beginReg;
   logic [31:0] addressReg;
   logic [7:0]  burstReg;

   logic        ciSelect, busy, startScan, grantTaken;
   logic [4:0]  burstWords;
   logic [17:0] scanWords;
   logic [31:0] readData;
   logic [3:0]  fgMask;
   logic [2:0]  fgCount;
   logic [9:0]  firstX, lastX;
   logic [31:0] wordSumX;
   logic        unusedBits;

   assign ciSelect   = ciStart & ciCke & (ciN == customInstructionId);
   assign ciDone     = ciSelect;
   // drainDone covers the cycle between the last burst ending and done rising.
   assign busy       = (state != IDLE) | pipeValid | drainDone;
   assign startScan  = ciSelect & (ciValueA[3:0] == 4'd2) & ~busy;
   assign scanWords  = 18'(width[9:2]) * 18'(height);
   assign burstWords = (wordsLeft > 18'd16) ? 5'd16 : wordsLeft[4:0];
   assign grantTaken = (state == REQUEST) & bus.busGrant & ~bus.busErrorIn;
   assign unusedBits = ^{ciValueA[31:4], ciValueB[31:26], ciValueB[15:10], ciValueB[1:0]};

   assign bus.requestBus          = (state == REQUEST);
   assign bus.endTransactionOut   = (state == ABORT);
   assign bus.beginTransactionOut = beginReg;
   assign bus.addressDataOut      = addressReg;
   assign bus.readNotWriteOut     = beginReg;
   assign bus.byteEnablesOut      = {4{beginReg}};
   assign bus.burstSizeOut        = burstReg;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (startScan && scanWords != 18'd0) nextState = REQUEST;
         REQUEST: if (bus.busErrorIn) nextState = ABORT;
                  else if (bus.busGrant) nextState = INIT;
         INIT:    nextState = bus.busErrorIn ? ABORT : READ;
         READ:    if (bus.busErrorIn) nextState = ABORT;
                  else if (bus.endTransactionIn) nextState = (wordsLeft != 18'd0) ? REQUEST : IDLE;
         ABORT:   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      fgMask   = '0;
      fgCount  = '0;
      firstX   = '0;
      lastX    = '0;
      wordSumX = '0;
      for (int k = 0; k < 4; k++) fgMask[k] = |pipeWord[8*k +: 8];
      for (int k = 3; k >= 0; k--) if (fgMask[k]) firstX = pipeX + 10'(k);
      for (int k = 0; k < 4; k++) begin
         if (fgMask[k]) begin
            fgCount  = fgCount + 3'd1;
            wordSumX = wordSumX + 32'(pipeX) + 32'(k);
            lastX    = pipeX + 10'(k);
         end
      end
   end

   always_comb begin
      readData = '0;
      case (ciValueA[3:0])
         4'd3:    readData = {29'd0, error, done, busy};
         4'd4:    readData = {6'd0, minY, 6'd0, minX};
         4'd5:    readData = {6'd0, maxY, 6'd0, maxX};
         4'd6:    readData = {12'd0, count};
         4'd7:    readData = sumX;
         4'd8:    readData = sumY;
         default: readData = '0;
      endcase
      ciResult = ciSelect ? readData : 32'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         base <= '0;  width <= '0;  height <= '0;  address <= '0;  wordsLeft <= '0;
         x <= '0;  y <= '0;  done <= 1'b0;  error <= 1'b0;  drainDone <= 1'b0;
         minX <= 10'h3FF;  minY <= 10'h3FF;  maxX <= '0;  maxY <= '0;
         count <= '0;  sumX <= '0;  sumY <= '0;
         pipeValid <= 1'b0;  pipeWord <= '0;  pipeX <= '0;  pipeY <= '0;
         beginReg <= 1'b0;  addressReg <= '0;  burstReg <= '0;
      end else begin
         beginReg   <= 1'b0;
         addressReg <= '0;
         burstReg   <= '0;
         pipeValid  <= 1'b0;
         drainDone  <= 1'b0;
         if (drainDone)       done  <= 1'b1;
         if (state == ABORT)  error <= 1'b1;

         if (grantTaken) begin
            beginReg   <= 1'b1;
            addressReg <= address;
            burstReg   <= 8'(burstWords) - 8'd1;
            address    <= address + 32'({burstWords, 2'b00});
            wordsLeft  <= wordsLeft - 18'(burstWords);
         end

         if (state == READ && bus.dataValidIn) begin
            pipeValid <= 1'b1;
            pipeWord  <= bus.addressDataIn;
            pipeX     <= x;
            pipeY     <= y;
            if (11'(x) + 11'd4 == 11'(width)) begin
               x <= '0;
               y <= y + 10'd1;
            end else begin
               x <= x + 10'd4;
            end
         end

         if (state == READ && !bus.busErrorIn && bus.endTransactionIn && wordsLeft == 18'd0)
            drainDone <= 1'b1;

         if (pipeValid) begin
            count <= count + 20'(fgCount);
            sumX  <= sumX + wordSumX;
            sumY  <= sumY + 32'(pipeY) * 32'(fgCount);
            if (fgMask != 4'd0) begin
               if (firstX < minX) minX <= firstX;
               if (lastX > maxX)  maxX <= lastX;
               if (pipeY < minY)  minY <= pipeY;
               if (pipeY > maxY)  maxY <= pipeY;
            end
         end

         if (ciSelect && !busy) begin
            if (ciValueA[3:0] == 4'd0) base <= {ciValueB[31:2], 2'b00};
            if (ciValueA[3:0] == 4'd1) begin
               width  <= {ciValueB[9:2], 2'b00};
               height <= ciValueB[25:16];
            end
         end

         if (startScan) begin
            done  <= (scanWords == 18'd0);
            error <= 1'b0;
            minX  <= 10'h3FF;  minY <= 10'h3FF;  maxX <= '0;  maxY <= '0;
            count <= '0;  sumX <= '0;  sumY <= '0;
            x <= '0;  y <= '0;
            address   <= base;
            wordsLeft <= scanWords;
         end
      end
   end
endmodule

// File: tb/tb_blob_bbox_scanner.sv
// Directed bench for blob_bbox_scanner: a small burst-memory slave plus CI command tasks.
module tb_blob_bbox_scanner;
   logic        clock = 1'b0;
   logic        reset;
   logic        ciStart, ciCke;
   logic [7:0]  ciN;
   logic [31:0] ciValueA, ciValueB, ciResult;
   logic        ciDone;

   blob_bbox_scanner_if bus ();

   blob_bbox_scanner #(.customInstructionId(8'd0)) dut (
      .clock    (clock),
      .reset    (reset),
      .ciStart  (ciStart),
      .ciCke    (ciCke),
      .ciN      (ciN),
      .ciValueA (ciValueA),
      .ciValueB (ciValueB),
      .ciResult (ciResult),
      .ciDone   (ciDone),
      .bus      (bus)
   );

   always #5 clock = ~clock;

   int          testsRun = 0;
   int          testsFailed = 0;
   logic [31:0] mem [logic [31:0]];
   int          beginCount, reqCycles, endTxPulses, beatsLeft, beatsServed;
   int          errorOnBurst, errorAfterBeats;
   logic [31:0] slaveAddr;
   logic [31:0] burstAddr [0:7];
   logic [7:0]  burstLen [0:7];
   logic [31:0] resetExpected [3:9];

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic ciOp(input logic [3:0] cmd, input logic [31:0] operand,
                       output logic [31:0] result, output logic doneFlag);
      @(negedge clock);
      ciStart  = 1'b1;
      ciCke    = 1'b1;
      ciN      = 8'd0;
      ciValueA = {28'd0, cmd};
      ciValueB = operand;
      #1;
      result   = ciResult;
      doneFlag = ciDone;
      @(posedge clock);
      #1;
      ciStart  = 1'b0;
      ciValueA = '0;
      ciValueB = '0;
   endtask

   task automatic ciRead(input logic [3:0] cmd, output logic [31:0] result);
      logic d;
      ciOp(cmd, 32'd0, result, d);
   endtask

   task automatic ciWrite(input logic [3:0] cmd, input logic [31:0] operand);
      logic [31:0] r;
      logic        d;
      ciOp(cmd, operand, r, d);
   endtask

   task automatic clearCounters();
      beginCount  = 0;
      reqCycles   = 0;
      endTxPulses = 0;
   endtask

   task automatic waitIdle(output logic [31:0] status);
      int polls;
      polls = 0;
      ciRead(4'd3, status);
      while (status[0] === 1'b1 && polls < 400) begin
         ciRead(4'd3, status);
         polls++;
      end
      check("scan finished in budget", 32'(status[0]), 32'd0);
   endtask

   function automatic logic [31:0] busOutputs();
      return {bus.requestBus, bus.beginTransactionOut, bus.readNotWriteOut,
              bus.endTransactionOut, bus.byteEnablesOut, bus.burstSizeOut, 16'd0}
             | bus.addressDataOut;
   endfunction

   // Burst-read slave: grants on request, streams one word per cycle after begin.
   initial begin
      bus.busGrant = 1'b0;  bus.dataValidIn = 1'b0;  bus.endTransactionIn = 1'b0;
      bus.busErrorIn = 1'b0;  bus.addressDataIn = '0;
      beatsLeft = 0;
      forever begin
         @(negedge clock);
         bus.busGrant = 1'b0;  bus.dataValidIn = 1'b0;  bus.endTransactionIn = 1'b0;
         bus.busErrorIn = 1'b0;  bus.addressDataIn = '0;
         if (reset) begin
            beatsLeft = 0;
         end else begin
            if (bus.requestBus) begin
               reqCycles++;
               bus.busGrant = 1'b1;
            end
            if (bus.endTransactionOut) endTxPulses++;
            if (beatsLeft > 0) begin
               if (beginCount == errorOnBurst && beatsServed == errorAfterBeats) begin
                  bus.busErrorIn = 1'b1;
                  beatsLeft = 0;
               end else begin
                  bus.dataValidIn   = 1'b1;
                  bus.addressDataIn = mem.exists(slaveAddr) ? mem[slaveAddr] : 32'd0;
                  slaveAddr   = slaveAddr + 32'd4;
                  beatsServed++;
                  beatsLeft--;
                  if (beatsLeft == 0) bus.endTransactionIn = 1'b1;
               end
            end
            if (bus.beginTransactionOut) begin
               if (beginCount < 8) begin
                  burstAddr[beginCount] = bus.addressDataOut;
                  burstLen[beginCount]  = bus.burstSizeOut;
               end
               beginCount++;
               slaveAddr   = bus.addressDataOut;
               beatsLeft   = int'(bus.burstSizeOut) + 1;
               beatsServed = 0;
            end
         end
      end
   end

   initial begin
      logic [31:0] r, status, reqSnapshot;
      logic        d;
      int          waitCycles;
      resetExpected = '{32'd0, 32'h03FF03FF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      ciStart = 1'b0;  ciCke = 1'b0;  ciN = 8'd0;  ciValueA = '0;  ciValueB = '0;
      errorOnBurst = -1;  errorAfterBeats = 0;
      clearCounters();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      check("ciResult unselected", ciResult, 32'd0);
      check("bus outputs after reset", busOutputs(), 32'd0);
      for (int c = 3; c <= 9; c++) begin
         ciRead(4'(c), r);
         check($sformatf("reset read cmd %0d", c), r, resetExpected[c]);
      end

      // Small frame, one burst of 4 words
      mem.delete();
      mem[32'h1004] = 32'hFF00FF00;
      ciWrite(4'd0, 32'h0000_1000);
      ciWrite(4'd1, 32'h0002_0008);
      clearCounters();
      ciOp(4'd2, 32'd0, r, d);
      check("ciDone on start", 32'(d), 32'd1);
      waitIdle(status);
      check("t1 status", status, 32'd2);
      check("t1 bursts", beginCount, 32'd1);
      check("t1 burst addr", burstAddr[0], 32'h0000_1000);
      check("t1 burst size", 32'(burstLen[0]), 32'd3);
      ciRead(4'd4, r);  check("t1 min", r, 32'h0000_0005);
      ciRead(4'd5, r);  check("t1 max", r, 32'h0000_0007);
      ciRead(4'd6, r);  check("t1 count", r, 32'd2);
      ciRead(4'd7, r);  check("t1 sumX", r, 32'd12);
      ciRead(4'd8, r);  check("t1 sumY", r, 32'd0);

      // 64x2 frame: two full bursts, single pixel at (63,1)
      mem.delete();
      mem[32'h207C] = 32'h5A00_0000;
      ciWrite(4'd0, 32'h0000_2000);
      ciWrite(4'd1, 32'h0002_0040);
      clearCounters();
      ciWrite(4'd2, 32'd0);
      waitIdle(status);
      check("t2 status", status, 32'd2);
      check("t2 bursts", beginCount, 32'd2);
      check("t2 burst0 addr", burstAddr[0], 32'h0000_2000);
      check("t2 burst1 addr", burstAddr[1], 32'h0000_2040);
      check("t2 burst sizes", {burstLen[0], burstLen[1]}, 32'h0000_0F0F);
      ciRead(4'd4, r);  check("t2 min", r, 32'h0001_003F);
      ciRead(4'd5, r);  check("t2 max", r, 32'h0001_003F);
      ciRead(4'd6, r);  check("t2 count", r, 32'd1);
      ciRead(4'd7, r);  check("t2 sumX", r, 32'd63);
      ciRead(4'd8, r);  check("t2 sumY", r, 32'd1);

      // Bus error during the second burst
      errorOnBurst = 2;  errorAfterBeats = 3;
      clearCounters();
      ciWrite(4'd2, 32'd0);
      waitIdle(status);
      check("t3 status", status, 32'd4);
      check("t3 endTx pulses", endTxPulses, 32'd1);
      check("t3 bursts", beginCount, 32'd2);
      reqSnapshot = 32'(reqCycles);
      repeat (20) @(posedge clock);
      #1 check("t3 no request after abort", reqCycles, reqSnapshot);
      errorOnBurst = -1;

      // Zero-height frame finishes at once without bus traffic
      ciWrite(4'd1, 32'h0000_0008);
      clearCounters();
      ciWrite(4'd2, 32'd0);
      ciRead(4'd3, r);
      check("t4 status next cycle", r, 32'd2);
      repeat (5) @(posedge clock);
      #1 check("t4 no request", reqCycles, 32'd0);

      // Start and base write while running are ignored
      ciWrite(4'd1, 32'h0002_0040);
      clearCounters();
      ciWrite(4'd2, 32'd0);
      waitCycles = 0;
      while (beginCount < 1 && waitCycles < 50) begin
         @(negedge clock);  #1;
         waitCycles++;
      end
      ciOp(4'd2, 32'd0, r, d);
      check("t5 ciDone while busy", 32'(d), 32'd1);
      ciWrite(4'd0, 32'h0000_5000);
      ciRead(4'd3, r);
      check("t5 busy status", r, 32'd1);
      waitIdle(status);
      check("t5 status", status, 32'd2);
      check("t5 bursts", beginCount, 32'd2);
      check("t5 burst1 addr", burstAddr[1], 32'h0000_2040);
      ciRead(4'd6, r);  check("t5 count", r, 32'd1);

      // Reset while in READ
      clearCounters();
      ciWrite(4'd2, 32'd0);
      waitCycles = 0;
      while (bus.beginTransactionOut !== 1'b1 && waitCycles < 50) begin
         @(negedge clock);  #1;
         waitCycles++;
      end
      check("t6 burst began", 32'(bus.beginTransactionOut), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);  #1;
      check("t6 bus outputs in reset", busOutputs(), 32'd0);
      check("t6 ciResult in reset", ciResult, 32'd0);
      ciRead(4'd3, r);
      check("t6 status in reset", r, 32'd0);
      reset = 1'b0;
      ciRead(4'd4, r);
      check("t6 bbox cleared", r, 32'h03FF_03FF);
      ciWrite(4'd2, 32'd0);
      ciRead(4'd3, r);
      check("t6 empty frame after reset", r, 32'd2);
      check("t6 bursts", beginCount, 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
